chunk_shift_register: RTL and testbench

- Parametrised successor to the single-bit shift register.
- Parallel-loads a WIDTH-bit word, then shifts it out STEP bits per handshake, MSB-first or LSB-first. The direction is selected at runtime, per word.
- Shifts STEP bits of shift_in into the vacated end on each handshake, so the block works as PISO and SIPO at the same time.
- Feeds packed matrix/pixel words into narrow datapaths of the LCMV classifier, and collects narrow results back into words.

---
 rtl/chunk_shift_pkg.sv | 18 +
 rtl/chunk_shift_register.sv | 103 ++++++++++
 tb/tb_chunk_shift_register.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/chunk_shift_pkg.sv
// Shared types and helpers for the chunked shift register.
// Imported by chunk_shift_register.
package chunk_shift_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } shift_state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Chunk counter width; a one-chunk word still needs a 1-bit counter.
   function automatic int cnt_width(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/chunk_shift_register.sv
// Parallel-load word, shifted out STEP bits per handshake while
// shift_in fills the vacated end (PISO and SIPO at once).
module chunk_shift_register
   import chunk_shift_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int STEP  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_dir,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [STEP-1:0]  shift_in,
   output logic [STEP-1:0]  out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   input  logic             abort,
   output logic [WIDTH-1:0] par_out,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / STEP;
   localparam int CW     = cnt_width(NCHUNK);
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   generate
      if ((WIDTH % STEP) != 0 || STEP < 1 || STEP > WIDTH) begin : g_bad_params
         $error("chunk_shift_register: WIDTH must be a multiple of STEP");
      end
   endgenerate

   shift_state_t     state;
   logic [WIDTH-1:0] data_q;
   logic             dir_q;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] shl;
   logic [WIDTH-1:0] shr;

   // A full-width step replaces the whole register with shift_in.
   generate
      if (STEP == WIDTH) begin : g_full
         assign shl = shift_in;
         assign shr = shift_in;
      end else begin : g_part
         assign shl = {data_q[WIDTH-STEP-1:0], shift_in};
         assign shr = {shift_in, data_q[WIDTH-1:STEP]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         data_q <= '0;
         dir_q  <= DIR_LEFT;
         cnt    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (load_valid) begin
                  data_q <= load_data;
                  dir_q  <= load_dir;
                  cnt    <= '0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (abort) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (out_ready) begin
                  data_q <= (dir_q == DIR_RIGHT) ? shr : shl;
                  if (cnt == LAST) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy       = (state == SHIFT);
   assign out_valid  = busy;
   assign load_ready = (state == IDLE);
   assign out_last   = busy && (cnt == LAST);
   assign par_out    = data_q;

   always_comb begin
      out_data = '0;
      if (busy) begin
         if (dir_q == DIR_RIGHT) out_data = data_q[STEP-1:0];
         else                    out_data = data_q[WIDTH-1 -: STEP];
      end
   end

endmodule

// File: tb/tb_chunk_shift_register.sv
// Directed and randomized checks of chunk_shift_register against
// a chunk-list reference model.
module tb_chunk_shift_register;

   localparam int W = 16;
   localparam int S = 4;
   localparam int N = W / S;

   typedef logic [S-1:0] chunk_q_t[$];

   logic         clk;
   logic         rst;
   logic [W-1:0] load_data;
   logic         load_dir;
   logic         load_valid;
   logic         load_ready;
   logic [S-1:0] shift_in;
   logic [S-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic         abort;
   logic [W-1:0] par_out;
   logic         busy;

   int checks = 0;
   int errors = 0;

   chunk_shift_register #(.WIDTH(W), .STEP(S)) dut (
      .clk(clk), .rst(rst),
      .load_data(load_data), .load_dir(load_dir),
      .load_valid(load_valid), .load_ready(load_ready),
      .shift_in(shift_in), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .abort(abort),
      .par_out(par_out), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   // k-th outgoing chunk of a word, straight from the word's layout
   function automatic logic [S-1:0] chunk_of(input logic [W-1:0] d, input logic dr, input int k);
      if (!dr) return S'(d >> ((N - 1 - k) * S));
      return S'(d >> (k * S));
   endfunction

   // register image after k chunks consumed with inserted chunks s
   function automatic logic [W-1:0] par_of(input logic [W-1:0] d, input logic dr,
                                           input int k, input chunk_q_t s);
      logic [W-1:0] p;
      if (!dr) begin
         p = (k >= N) ? '0 : d << (k * S);
         for (int j = 0; j < k; j++) p |= W'(s[j]) << ((k - 1 - j) * S);
      end else begin
         p = (k >= N) ? '0 : d >> (k * S);
         for (int j = 0; j < k; j++) p |= W'(s[j]) << ((N - k + j) * S);
      end
      return p;
   endfunction

   logic [3:0] exp_msb[4];
   logic [3:0] exp_lsb[4];
   logic [3:0] exp_bp[4];
   logic       bp_rdy[7];

   // reference model state
   logic         m_busy;
   logic [W-1:0] m_d;
   logic         m_dir;
   int           m_k;
   chunk_q_t     m_s;
   logic [W-1:0] m_idle_par;
   logic [W-1:0] m_par;

   initial begin
      exp_msb = '{4'hA, 4'h5, 4'hC, 4'h3};
      exp_lsb = '{4'h3, 4'hC, 4'h5, 4'hA};
      exp_bp  = '{4'h1, 4'h2, 4'h3, 4'h4};
      bp_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      rst = 1'b0; load_data = 16'hA5C3; load_dir = 1'b0; load_valid = 1'b1;
      shift_in = '0; out_ready = 1'b0; abort = 1'b0;

      // reset held with load_valid asserted
      for (int i = 0; i < 3; i++) begin
         edge_step();
         chk("rst_load_ready", load_ready, 1);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_par", par_out, 0);
         chk("rst_out_data", out_data, 0);
         chk("rst_busy", busy, 0);
         chk("rst_out_last", out_last, 0);
      end

      // MSB-first, load accepted on first edge out of reset
      rst = 1'b1;
      edge_step();
      load_valid = 1'b0;
      chk("msb_valid", out_valid, 1);
      out_ready = 1'b1; shift_in = 4'hF;
      for (int i = 0; i < 4; i++) begin
         chk("msb_data", out_data, exp_msb[i]);
         chk("msb_last", out_last, (i == 3));
         edge_step();
      end
      chk("msb_ready_after", load_ready, 1);
      chk("msb_par", par_out, 16'hFFFF);

      // LSB-first
      load_data = 16'hA5C3; load_dir = 1'b1; load_valid = 1'b1;
      edge_step();
      load_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         shift_in = S'(i + 1);
         chk("lsb_data", out_data, exp_lsb[i]);
         chk("lsb_last", out_last, (i == 3));
         edge_step();
      end
      chk("lsb_par", par_out, 16'h4321);
      chk("lsb_idle", out_valid, 0);

      // backpressure
      load_data = 16'h1234; load_dir = 1'b0; load_valid = 1'b1; shift_in = '0;
      edge_step();
      load_valid = 1'b0;
      begin
         int hs;
         hs = 0;
         for (int i = 0; i < 7; i++) begin
            out_ready = bp_rdy[i];
            chk("bp_valid", out_valid, (hs < 4));
            if (hs < 4) begin
               chk("bp_data", out_data, exp_bp[hs]);
               chk("bp_last", out_last, (hs == 3));
            end
            edge_step();
            if (bp_rdy[i] && hs < 4) hs++;
         end
      end
      chk("bp_done", load_ready, 1);
      chk("bp_par", par_out, 16'h0000);

      // abort after two handshakes
      out_ready = 1'b1;
      load_data = 16'hBEEF; load_dir = 1'b0; load_valid = 1'b1;
      edge_step();
      load_valid = 1'b0;
      edge_step();
      edge_step();
      abort = 1'b1;
      edge_step();
      abort = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_ready", load_ready, 1);
      chk("abort_par", par_out, 16'hEF00);
      edge_step();
      chk("abort_par_hold", par_out, 16'hEF00);

      // reset mid-word
      load_valid = 1'b1;
      edge_step();
      load_valid = 1'b0;
      edge_step();
      edge_step();
      rst = 1'b0;
      edge_step();
      rst = 1'b1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_par", par_out, 0);

      // load while busy is ignored, then taken in the next idle cycle
      load_data = 16'hA5C3; load_dir = 1'b0; load_valid = 1'b1;
      edge_step();
      load_data = 16'h5555;
      for (int i = 0; i < 4; i++) begin
         chk("lwb_data", out_data, exp_msb[i]);
         edge_step();
      end
      chk("lwb_idle_gap", load_ready, 1);
      edge_step();
      load_valid = 1'b0;
      chk("lwb_new_valid", out_valid, 1);
      chk("lwb_new_data", out_data, 4'h5);
      for (int i = 0; i < 4; i++) edge_step();

      // randomized run against the reference model
      rst = 1'b0;
      edge_step();
      rst = 1'b1;
      m_busy = 1'b0; m_idle_par = '0; m_k = 0; m_d = '0; m_dir = 1'b0;
      m_s.delete();
      for (int c = 0; c < 400; c++) begin
         rst        = ($urandom_range(0, 59) != 0);
         load_valid = ($urandom_range(0, 2) == 0);
         load_data  = W'($urandom);
         load_dir   = 1'($urandom);
         out_ready  = ($urandom_range(0, 3) != 0);
         shift_in   = S'($urandom);
         abort      = ($urandom_range(0, 15) == 0);
         m_par = m_busy ? par_of(m_d, m_dir, m_k, m_s) : m_idle_par;
         chk("rnd_load_ready", load_ready, !m_busy);
         chk("rnd_out_valid", out_valid, m_busy);
         chk("rnd_par", par_out, m_par);
         if (m_busy) begin
            chk("rnd_out_data", out_data, chunk_of(m_d, m_dir, m_k));
            chk("rnd_out_last", out_last, (m_k == N - 1));
         end
         edge_step();
         if (!rst) begin
            m_busy = 1'b0;
            m_idle_par = '0;
         end else if (!m_busy) begin
            if (load_valid) begin
               m_busy = 1'b1; m_d = load_data; m_dir = load_dir;
               m_k = 0; m_s.delete();
            end
         end else if (abort) begin
            m_idle_par = par_of(m_d, m_dir, m_k, m_s);
            m_busy = 1'b0;
         end else if (out_ready) begin
            m_s.push_back(shift_in);
            m_k++;
            if (m_k == N) begin
               m_idle_par = par_of(m_d, m_dir, m_k, m_s);
               m_busy = 1'b0;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
